// File: rtl/lathe_cycle_sequencer.sv
// Auto-cycle controller for the retrofitted lathe: spin-up, feed, retract and index per part,
// with AUTO/MAN arbitration, e-stop, feed/retract watchdogs and fault latching.
module lathe_cycle_sequencer #(
  parameter int SPINUP_TICKS  = 150_000_000,
  parameter int FEED_TICKS    = 500_000_000,
  parameter int RETRACT_TICKS = 500_000_000,
  parameter int BATCH_SIZE    = 5,
  parameter int TMR_W         = 29
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       estop,
  input  logic       fault_clr,
  input  logic       auto_mode,
  input  logic       man_mode,
  input  logic       feed_limit,
  input  logic       home_sw,
  output logic       spindle_on,
  output logic       feed_fwd,
  output logic       feed_rev,
  output logic       busy,
  output logic       batch_done,
  output logic       fault,
  output logic [3:0] part_count,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_SPINUP     = 3'd1,
    S_FEED       = 3'd2,
    S_RETRACT    = 3'd3,
    S_INDEX      = 3'd4,
    S_BATCH_DONE = 3'd5,
    S_FAULT      = 3'd6,
    S_MANUAL     = 3'd7
  } state_t;

  localparam logic [TMR_W-1:0] SPINUP_LAST  = TMR_W'(SPINUP_TICKS - 1);
  localparam logic [TMR_W-1:0] FEED_LAST    = TMR_W'(FEED_TICKS - 1);
  localparam logic [TMR_W-1:0] RETRACT_LAST = TMR_W'(RETRACT_TICKS - 1);
  localparam logic [3:0]       BATCH_N      = 4'(BATCH_SIZE);

  state_t           st;
  state_t           st_nx;
  logic [TMR_W-1:0] timer;
  logic [3:0]       count_nx;
  logic             stop_pending;
  logic             pend_nx;
  logic             start_d;
  logic             start_rise;
  logic             auto_sel;
  logic             man_sel;
  logic             stop_req;

  assign start_rise = start & ~start_d;
  assign auto_sel   = auto_mode & ~man_mode;
  assign man_sel    = man_mode & ~auto_mode;
  // Losing the AUTO selection mid-cycle is handled exactly like the stop button.
  assign stop_req   = stop | ~auto_sel;
  assign state      = st;

  always_comb begin
    st_nx    = st;
    pend_nx  = stop_pending;
    count_nx = part_count;
    if (estop && st != S_FAULT) begin
      st_nx = S_FAULT;
    end else begin
      case (st)
        S_IDLE: begin
          if (auto_sel && start_rise) begin
            st_nx = S_SPINUP;
            if (part_count == BATCH_N) count_nx = '0;
          end else if (man_sel) begin
            st_nx = S_MANUAL;
          end
        end
        S_SPINUP: begin
          if (stop_req)                  st_nx = S_IDLE;
          else if (timer == SPINUP_LAST) st_nx = S_FEED;
        end
        S_FEED: begin
          if (stop_req) begin
            st_nx   = S_RETRACT;
            pend_nx = 1'b1;
          end else if (feed_limit) begin
            st_nx = S_RETRACT;
          end else if (timer == FEED_LAST) begin
            st_nx = S_FAULT;
          end
        end
        S_RETRACT: begin
          // A stop here never aborts the retract; it only marks the part as abandoned.
          pend_nx = stop_pending | stop_req;
          if (home_sw)                    st_nx = pend_nx ? S_IDLE : S_INDEX;
          else if (timer == RETRACT_LAST) st_nx = S_FAULT;
        end
        S_INDEX: begin
          count_nx = part_count + 4'd1;
          if (count_nx == BATCH_N) st_nx = S_BATCH_DONE;
          else if (stop_req)       st_nx = S_IDLE;
          else                     st_nx = S_FEED;
        end
        S_BATCH_DONE: begin
          if (auto_sel && start_rise) begin
            st_nx    = S_SPINUP;
            count_nx = '0;
          end else if (man_sel) begin
            st_nx = S_MANUAL;
          end
        end
        S_MANUAL: begin
          if (!man_sel) st_nx = S_IDLE;
        end
        S_FAULT: begin
          if (fault_clr && !estop) st_nx = S_IDLE;
        end
        default: st_nx = S_IDLE;
      endcase
    end
    if (st_nx != S_RETRACT) pend_nx = 1'b0;
  end

  // Outputs are decoded from the next state so they are registered alongside it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st           <= S_IDLE;
      timer        <= '0;
      part_count   <= '0;
      stop_pending <= 1'b0;
      start_d      <= 1'b0;
      spindle_on   <= 1'b0;
      feed_fwd     <= 1'b0;
      feed_rev     <= 1'b0;
      busy         <= 1'b0;
      batch_done   <= 1'b0;
      fault        <= 1'b0;
    end else begin
      st           <= st_nx;
      start_d      <= start;
      stop_pending <= pend_nx;
      part_count   <= count_nx;
      if (st_nx == st && (st inside {S_SPINUP, S_FEED, S_RETRACT}))
        timer <= timer + TMR_W'(1);
      else
        timer <= '0;
      spindle_on <= (st_nx inside {S_SPINUP, S_FEED, S_RETRACT, S_INDEX}) ||
                    (st_nx == S_MANUAL && start);
      feed_fwd   <= (st_nx == S_FEED);
      feed_rev   <= (st_nx == S_RETRACT);
      busy       <= (st_nx inside {S_SPINUP, S_FEED, S_RETRACT, S_INDEX});
      batch_done <= (st_nx == S_BATCH_DONE);
      fault      <= (st_nx == S_FAULT);
    end
  end

endmodule

// File: tb/tb_lathe_cycle_sequencer.sv
// Self-checking bench for lathe_cycle_sequencer: directed plan steps followed by randomized
// machining episodes, with expected state sequences derived from phase lengths and trigger cycles.
module tb_lathe_cycle_sequencer;

  localparam int SPIN_T = 4;
  localparam int FEED_T = 20;
  localparam int RET_T  = 20;
  localparam int BATCH  = 2;

  localparam int ST_IDLE    = 0;
  localparam int ST_SPINUP  = 1;
  localparam int ST_FEED    = 2;
  localparam int ST_RETRACT = 3;
  localparam int ST_INDEX   = 4;
  localparam int ST_BATCH   = 5;
  localparam int ST_FAULT   = 6;
  localparam int ST_MANUAL  = 7;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       estop;
  logic       fault_clr;
  logic       auto_mode;
  logic       man_mode;
  logic       feed_limit;
  logic       home_sw;
  logic       spindle_on;
  logic       feed_fwd;
  logic       feed_rev;
  logic       busy;
  logic       batch_done;
  logic       fault;
  logic [3:0] part_count;
  logic [2:0] state;

  int n_assert;
  int n_fail;
  int m_count;
  bit start_snap;

  lathe_cycle_sequencer #(
    .SPINUP_TICKS (SPIN_T),
    .FEED_TICKS   (FEED_T),
    .RETRACT_TICKS(RET_T),
    .BATCH_SIZE   (BATCH),
    .TMR_W        (29)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .estop     (estop),
    .fault_clr (fault_clr),
    .auto_mode (auto_mode),
    .man_mode  (man_mode),
    .feed_limit(feed_limit),
    .home_sw   (home_sw),
    .spindle_on(spindle_on),
    .feed_fwd  (feed_fwd),
    .feed_rev  (feed_rev),
    .busy      (busy),
    .batch_done(batch_done),
    .fault     (fault),
    .part_count(part_count),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected Moore outputs follow directly from the state the model says we are in.
  task automatic check_all(input int st);
    logic e_spin;
    e_spin = ((st >= ST_SPINUP && st <= ST_INDEX) || (st == ST_MANUAL && start_snap));
    chk("state",      {5'd0, state},      8'(st));
    chk("part_count", {4'd0, part_count}, 8'(m_count));
    chk("spindle_on", {7'd0, spindle_on}, {7'd0, e_spin});
    chk("feed_fwd",   {7'd0, feed_fwd},   {7'd0, (st == ST_FEED)});
    chk("feed_rev",   {7'd0, feed_rev},   {7'd0, (st == ST_RETRACT)});
    chk("busy",       {7'd0, busy},       {7'd0, (st >= ST_SPINUP && st <= ST_INDEX)});
    chk("batch_done", {7'd0, batch_done}, {7'd0, (st == ST_BATCH)});
    chk("fault",      {7'd0, fault},      {7'd0, (st == ST_FAULT)});
    chk("fwd_rev_excl", {7'd0, (feed_fwd & feed_rev)}, 8'd0);
  endtask

  task automatic tick(input int st);
    start_snap = start;
    @(posedge clk);
    #1;
    check_all(st);
  endtask

  // Start pulse then SPIN_T cycles of spin-up, unless stop is pressed after cycle ks.
  task automatic spinup_phase(input int ks, output int nxt);
    int n;
    n = (ks > 0 && ks <= SPIN_T) ? ks : SPIN_T;
    if (m_count == BATCH) m_count = 0;
    start = 1'b1;
    tick(ST_SPINUP);
    start = 1'b0;
    stop  = (ks == 1);
    for (int i = 2; i <= n; i++) begin
      tick(ST_SPINUP);
      stop = (i == ks);
    end
    nxt = (ks > 0) ? ST_IDLE : ST_FEED;
  endtask

  // Feed lasts until the first of feed_limit (kl) or stop (ks), else the watchdog expires.
  task automatic feed_phase(input int kl, input int ks, output int nxt, output bit pend);
    int n;
    n = FEED_T;
    if (kl > 0 && kl <= n) n = kl;
    if (ks > 0 && ks <= n) n = ks;
    for (int i = 1; i <= n; i++) begin
      tick(ST_FEED);
      feed_limit = (i == kl);
      stop       = (i == ks);
    end
    pend = (ks > 0 && ks == n);
    nxt  = ((kl > 0 && kl == n) || pend) ? ST_RETRACT : ST_FAULT;
  endtask

  // Retract lasts until home_sw (kh) or the watchdog; any stop seen before home abandons the part.
  task automatic retract_phase(input int kh, input int ks, input bit pend_in, output int nxt);
    int n;
    bit pend;
    n = (kh > 0 && kh <= RET_T) ? kh : RET_T;
    for (int i = 1; i <= n; i++) begin
      tick(ST_RETRACT);
      feed_limit = 1'b0;
      stop       = (i == ks);
      home_sw    = (i == kh);
    end
    pend = pend_in || (ks > 0 && ks <= n);
    nxt  = (kh > 0 && kh <= RET_T) ? (pend ? ST_IDLE : ST_INDEX) : ST_FAULT;
  endtask

  task automatic do_part(input int kl, input int ks, input int kh, input int ksr, output int fin);
    int  nxt;
    bit  pend;
    feed_phase(kl, ks, nxt, pend);
    if (nxt == ST_FAULT) begin
      tick(ST_FAULT);
      fin = ST_FAULT;
      return;
    end
    retract_phase(kh, ksr, pend, nxt);
    tick(nxt);
    home_sw = 1'b0;
    stop    = 1'b0;
    fin     = nxt;
    if (nxt == ST_INDEX) begin
      m_count++;
      if (m_count == BATCH) begin
        tick(ST_BATCH);
        fin = ST_BATCH;
      end
    end
  endtask

  task automatic clear_fault();
    fault_clr = 1'b1;
    tick(ST_IDLE);
    fault_clr = 1'b0;
  endtask

  task automatic random_episode();
    int nxt;
    int fin;
    int ksp;
    int kl;
    int ks;
    int kh;
    int ksr;
    ksp = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, SPIN_T)) : 0;
    spinup_phase(ksp, nxt);
    if (nxt == ST_IDLE) begin
      tick(ST_IDLE);
      stop = 1'b0;
      return;
    end
    fin = ST_INDEX;
    while (fin == ST_INDEX) begin
      kl  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, FEED_T));
      ks  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, FEED_T)) : 0;
      kh  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, RET_T));
      ksr = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, RET_T)) : 0;
      do_part(kl, ks, kh, ksr, fin);
    end
    if (fin == ST_FAULT) clear_fault();
  endtask

  initial begin
    int nxt;
    int fin;
    bit pend;
    n_assert   = 0;
    n_fail     = 0;
    m_count    = 0;
    start_snap = 1'b0;
    rst        = 1'b1;
    start      = 1'b0;
    stop       = 1'b0;
    estop      = 1'b0;
    fault_clr  = 1'b0;
    auto_mode  = 1'b0;
    man_mode   = 1'b0;
    feed_limit = 1'b0;
    home_sw    = 1'b0;

    @(posedge clk);
    #1;
    check_all(ST_IDLE);
    rst = 1'b0;
    tick(ST_IDLE);

    // Full batch: limit and home at the 5th cycle of each phase, twice.
    auto_mode = 1'b1;
    spinup_phase(0, nxt);
    do_part(5, 0, 5, 0, fin);
    do_part(5, 0, 5, 0, fin);
    tick(ST_BATCH);

    // Stop mid-feed: retract home and return to IDLE without counting.
    spinup_phase(0, nxt);
    do_part(0, 3, 4, 0, fin);

    // Feed watchdog, then fault_clr is ignored while estop is held.
    spinup_phase(0, nxt);
    do_part(0, 0, 0, 0, fin);
    estop     = 1'b1;
    fault_clr = 1'b1;
    tick(ST_FAULT);
    tick(ST_FAULT);
    estop = 1'b0;
    tick(ST_IDLE);
    fault_clr = 1'b0;

    // E-stop during RETRACT of the second part.
    spinup_phase(0, nxt);
    do_part(5, 0, 5, 0, fin);
    feed_phase(4, 0, nxt, pend);
    tick(ST_RETRACT);
    feed_limit = 1'b0;
    tick(ST_RETRACT);
    estop = 1'b1;
    tick(ST_FAULT);
    estop = 1'b0;
    clear_fault();

    // Mode arbitration: both selectors means neither mode.
    man_mode = 1'b1;
    start    = 1'b1;
    tick(ST_IDLE);
    start = 1'b0;
    tick(ST_IDLE);
    auto_mode = 1'b0;
    tick(ST_MANUAL);
    start = 1'b1;
    tick(ST_MANUAL);
    tick(ST_MANUAL);
    start = 1'b0;
    tick(ST_MANUAL);
    man_mode = 1'b0;
    tick(ST_IDLE);
    auto_mode = 1'b1;

    // Randomized machining episodes.
    for (int ep = 0; ep < 30; ep++) begin
      random_episode();
    end

    // Asynchronous reset in the middle of FEED.
    spinup_phase(0, nxt);
    tick(ST_FEED);
    tick(ST_FEED);
    tick(ST_FEED);
    #2;
    rst = 1'b1;
    #1;
    m_count    = 0;
    start_snap = 1'b0;
    check_all(ST_IDLE);
    rst = 1'b0;
    tick(ST_IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
